vga_scanout: RTL and testbench
==============================

# vga_scanout

Parametrised VGA scan-out engine, successor to the fixed 640x480 controller/video generator pair. It divides the system clock into a pixel enable and generates programmable sync/blank timing. It fetches indexed pixels from the frame buffer with optional integer upscaling and expands them to 24-bit RGB through a palette. The output pipeline keeps syncs and colour aligned.

## Interface
Parameters:
- H_ACTIVE, 640: visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48: horizontal porch and sync widths in pixels
- V_ACTIVE, 480: visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33: vertical porch and sync widths in lines
- SYNC_POL, 0: sync active level (0 = active-low)
- CLK_DIV, 2: clk cycles per pixel (≥2)
- SCALE_LOG2, 0: frame-buffer pixel replicated 2^SCALE_LOG2 times in x and in y
- DW, 4: pixel index width
- AW, 24: frame-buffer address width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- vgaclk  out  1  pixel clock to DAC, 50 % duty when CLK_DIV is even
- hsync, vsync  out  1  sync outputs at SYNC_POL
- sync_b  out  1  tied 0 (composite sync unused)
- blank_b  out  1  high during the visible area
- r, g, b  out  8 each  pixel colour, 0 when blanked
- address  out  AW  frame-buffer read address
- rd_en  out  1  address valid this pixel
- data  in  DW  frame-buffer read data
- frame_start  out  1  one-clk pulse at x=0, y=0
- pal_we  in  1  palette write strobe
- pal_idx  in  DW  palette entry
- pal_rgb  in  24  {r,g,b} to write

## Operation
- Divider counter 0..CLK_DIV-1. pix_tick is asserted when the counter wraps. vgaclk is high for the second half of the count.
- The x counter runs 0..H_TOTAL-1 on pix_tick; y increments when x wraps; y runs 0..V_TOTAL-1. H_TOTAL is the sum of the H parameters; V_TOTAL likewise.
- Active when x<H_ACTIVE and y<V_ACTIVE.
- hsync is asserted for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). vsync uses the same rule on y.
- Address generation is multiplier-free:
  - line_base advances by H_ACTIVE>>SCALE_LOG2 when y leaves each block of 2^SCALE_LOG2 lines.
  - col increments every 2^SCALE_LOG2 active pixels.
  - address = line_base + col.
  - line_base returns to 0 at frame wrap; col returns to 0 at each line start.
- rd_en is asserted only for active pixels. address holds its last value otherwise.
- Colour path: on the tick after an address is issued, data is looked up and the result registered into r/g/b. A blanked pixel registers 0.
- With the palette compiled in, the palette resets to grayscale: entry i = i*255/(2^DW-1) per channel.
- Palette writes take effect on the next clk. A write to an entry while it is being read returns the old value that cycle.

## Timing
- Reset values: all counters 0, vgaclk 0, hsync/vsync inactive (=~SYNC_POL), blank_b 0, r/g/b 0, address 0, rd_en 0, frame_start 0.
- Latency: the counter state at tick t drives address/rd_en registered at t. Data must be stable by tick t+1 (memory latency ≤ CLK_DIV clk).
- r/g/b, hsync, vsync and blank_b all change at tick t+1, mutually aligned.
- frame_start is asserted for 1 clk, on the clk where the counters wrap to (0,0).
- Reset mid-frame clears all state immediately. The first line after release starts at x=0, y=0.
- Wrap: x=H_TOTAL-1 and y=V_TOTAL-1 both return to 0 on the same tick.

## Configuration
- VGA_PALETTE_EN defined: 2^DW x 24 register palette, writable via pal_we/pal_idx/pal_rgb.
- VGA_PALETTE_EN undefined: fixed grayscale expansion. Each channel = {data replicated to 8 bits}, i.e. data*17 for DW=4. Palette ports are present but ignored.

## Structure
- Package vga_pkg holds:
  - the timing-struct typedef for H/V parameter sets;
  - localparams VGA_640x480 and VGA_800x600;
  - a function computing H_TOTAL/V_TOTAL.
- Sub-module vga_timing: divider, x/y counters, hsync/vsync/active/frame_start.
- The top level adds address generation, palette and the alignment registers.

## Test plan
- Defaults, 2 full frames → hsync period 1600 clk and low for 192 clk; vsync period 840 000 clk; frame_start every 840 000 clk.
- data=4'hF at pixel (0,0) → r=g=b=8'hFF with blank_b=1, one pixel after address=0 is issued.
- SCALE_LOG2=1:
  - address sequence on line 0 is 0,0,1,1,…,319,319;
  - lines 0 and 1 read identical addresses;
  - line 2 starts at 320.
- VGA_PALETTE_EN defined: write idx 3 = 24'h12_34_56, then display data=3 → r=8'h12, g=8'h34, b=8'h56. Entry 5 untouched → 8'h55 grey.
- Assert rst_n low at x=300, y=200 for 3 clk → all outputs reach reset values asynchronously; after release the first frame_start occurs 1 clk later.
- SYNC_POL=1, CLK_DIV=4 → hsync high-active, 96 pixels = 384 clk wide; blank_b=0 outside active; r/g/b=0 during blank.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared timing types, standard video modes and small helpers for the
// VGA scan-out engine (vga_timing, vga_scanout).
package vga_pkg;

  // One axis of a video mode: visible span, front porch, sync width, back porch.
  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } vga_axis_t;

  typedef struct packed {
    vga_axis_t h;
    vga_axis_t v;
  } vga_mode_t;

  localparam vga_mode_t VGA_640x480 = '{
    h: '{active: 640, fp: 16, sync: 96, bp: 48},
    v: '{active: 480, fp: 10, sync: 2, bp: 33}
  };

  localparam vga_mode_t VGA_800x600 = '{
    h: '{active: 800, fp: 40, sync: 128, bp: 88},
    v: '{active: 600, fp: 1, sync: 4, bp: 23}
  };

  // Total length of one axis (pixels per line or lines per frame).
  function automatic int unsigned vga_total(input vga_axis_t axis);
    return axis.active + axis.fp + axis.sync + axis.bp;
  endfunction

  // Grayscale ramp value for palette entry idx of a 2^dw entry table.
  function automatic logic [7:0] vga_gray(input int unsigned idx, input int unsigned dw);
    int unsigned max_idx;
    max_idx = (32'd1 << dw) - 32'd1;
    return 8'((idx * 32'd255) / max_idx);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing: pixel-enable divider, x/y raster counters and the raw
// hsync/vsync/active/frame_start decode for the VGA scan-out engine.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        SYNC_POL = 1'b0,
  parameter int unsigned CLK_DIV  = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_pix_tick,
  output logic o_vgaclk,
  output logic o_hsync,
  output logic o_vsync,
  output logic o_active,
  output logic o_y_active,
  output logic o_line_end,
  output logic o_frame_end,
  output logic o_frame_start
);

  localparam vga_axis_t   HAxis   = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
  localparam vga_axis_t   VAxis   = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
  localparam int unsigned HTotal  = vga_total(HAxis);
  localparam int unsigned VTotal  = vga_total(VAxis);
  localparam int unsigned DivW    = $clog2(CLK_DIV);
  localparam int unsigned XW      = $clog2(HTotal);
  localparam int unsigned YW      = $clog2(VTotal);
  localparam int unsigned HsStart = H_ACTIVE + H_FP;
  localparam int unsigned HsEnd   = HsStart + H_SYNC;
  localparam int unsigned VsStart = V_ACTIVE + V_FP;
  localparam int unsigned VsEnd   = VsStart + V_SYNC;

  logic [DivW-1:0] r_div;
  logic [DivW-1:0] w_div_d;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic            r_vgaclk;
  logic            r_first;
  logic            r_frame_start;
  logic            w_pix_tick;
  logic            w_x_last;
  logic            w_y_last;

  assign w_pix_tick = (r_div == DivW'(CLK_DIV - 1));
  assign w_div_d    = w_pix_tick ? '0 : r_div + DivW'(1);
  assign w_x_last   = (r_x == XW'(HTotal - 1));
  assign w_y_last   = (r_y == YW'(VTotal - 1));

  // Divider, raster counters, vgaclk and the frame_start pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div         <= '0;
      r_vgaclk      <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_first       <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_div         <= w_div_d;
      // vgaclk tracks the divider value it will hold: high in the upper half.
      r_vgaclk      <= (w_div_d >= DivW'(CLK_DIV / 2));
      r_first       <= 1'b0;
      // The counters already sit at (0,0) out of reset, so the first clock counts as a wrap.
      r_frame_start <= r_first | (w_pix_tick & w_x_last & w_y_last);
      if (w_pix_tick) begin
        if (w_x_last) begin
          r_x <= '0;
          r_y <= w_y_last ? '0 : r_y + YW'(1);
        end else begin
          r_x <= r_x + XW'(1);
        end
      end
    end
  end

  assign o_pix_tick    = w_pix_tick;
  assign o_vgaclk      = r_vgaclk;
  assign o_hsync       = ((r_x >= XW'(HsStart)) && (r_x < XW'(HsEnd))) ? SYNC_POL : ~SYNC_POL;
  assign o_vsync       = ((r_y >= YW'(VsStart)) && (r_y < YW'(VsEnd))) ? SYNC_POL : ~SYNC_POL;
  assign o_y_active    = (r_y < YW'(V_ACTIVE));
  assign o_active      = (r_x < XW'(H_ACTIVE)) && o_y_active;
  assign o_line_end    = w_pix_tick & w_x_last;
  assign o_frame_end   = w_pix_tick & w_x_last & w_y_last;
  assign o_frame_start = r_frame_start;

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: parametrised VGA scan-out engine. Wraps vga_timing, generates
// multiplier-free frame-buffer addresses with 2^SCALE_LOG2 pixel replication,
// expands indexed pixels to RGB and keeps colour aligned with the syncs.
// Define VGA_PALETTE_EN to replace the fixed grayscale expansion with a
// writable 2^DW x 24 palette.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = VGA_640x480.h.active,
  parameter int unsigned H_FP       = VGA_640x480.h.fp,
  parameter int unsigned H_SYNC     = VGA_640x480.h.sync,
  parameter int unsigned H_BP       = VGA_640x480.h.bp,
  parameter int unsigned V_ACTIVE   = VGA_640x480.v.active,
  parameter int unsigned V_FP       = VGA_640x480.v.fp,
  parameter int unsigned V_SYNC     = VGA_640x480.v.sync,
  parameter int unsigned V_BP       = VGA_640x480.v.bp,
  parameter logic        SYNC_POL   = 1'b0,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned SCALE_LOG2 = 0,
  parameter int unsigned DW         = 4,
  parameter int unsigned AW         = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          vgaclk,
  output logic          hsync,
  output logic          vsync,
  output logic          sync_b,
  output logic          blank_b,
  output logic [7:0]    r,
  output logic [7:0]    g,
  output logic [7:0]    b,
  output logic [AW-1:0] address,
  output logic          rd_en,
  input  logic [DW-1:0] data,
  output logic          frame_start,
  input  logic          pal_we,
  input  logic [DW-1:0] pal_idx,
  input  logic [23:0]   pal_rgb
);

  localparam int unsigned       SubW     = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;
  localparam logic [SubW-1:0]   SubMax   = SubW'((32'd1 << SCALE_LOG2) - 32'd1);
  localparam logic [AW-1:0]     LineStep = AW'(H_ACTIVE >> SCALE_LOG2);

  logic w_pix_tick;
  logic w_hsync;
  logic w_vsync;
  logic w_active;
  logic w_y_active;
  logic w_line_end;
  logic w_frame_end;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .SYNC_POL (SYNC_POL),
    .CLK_DIV  (CLK_DIV)
  ) u_timing (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .o_pix_tick    (w_pix_tick),
    .o_vgaclk      (vgaclk),
    .o_hsync       (w_hsync),
    .o_vsync       (w_vsync),
    .o_active      (w_active),
    .o_y_active    (w_y_active),
    .o_line_end    (w_line_end),
    .o_frame_end   (w_frame_end),
    .o_frame_start (frame_start)
  );

  logic [AW-1:0]   r_col;
  logic [AW-1:0]   r_line_base;
  logic [SubW-1:0] r_sub_x;
  logic [SubW-1:0] r_sub_y;
  logic [AW-1:0]   r_address;
  logic            r_rd_en;
  logic            r_hs1;
  logic            r_vs1;

  // Stage 1: issue the address for the current pixel and delay syncs to match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col       <= '0;
      r_line_base <= '0;
      r_sub_x     <= '0;
      r_sub_y     <= '0;
      r_address   <= '0;
      r_rd_en     <= 1'b0;
      r_hs1       <= ~SYNC_POL;
      r_vs1       <= ~SYNC_POL;
    end else if (w_pix_tick) begin
      r_rd_en <= w_active;
      r_hs1   <= w_hsync;
      r_vs1   <= w_vsync;
      if (w_active) begin
        r_address <= r_line_base + r_col;
        if (r_sub_x == SubMax) begin
          r_sub_x <= '0;
          r_col   <= r_col + AW'(1);
        end else begin
          r_sub_x <= r_sub_x + SubW'(1);
        end
      end
      if (w_line_end) begin
        r_col   <= '0;
        r_sub_x <= '0;
        if (w_frame_end) begin
          r_line_base <= '0;
          r_sub_y     <= '0;
        end else if (w_y_active) begin
          // Move to the next source line only after its last replicated copy.
          if (r_sub_y == SubMax) begin
            r_sub_y     <= '0;
            r_line_base <= r_line_base + LineStep;
          end else begin
            r_sub_y <= r_sub_y + SubW'(1);
          end
        end
      end
    end
  end

  logic [23:0] w_rgb;

`ifdef VGA_PALETTE_EN
  logic [23:0] r_pal [2**DW];

  // Palette storage; reset loads the grayscale ramp, writes land on the next clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**DW; i++) begin
        r_pal[i] <= {3{vga_gray(i, DW)}};
      end
    end else if (pal_we) begin
      r_pal[pal_idx] <= pal_rgb;
    end
  end

  assign w_rgb = r_pal[data];
`else
  logic [7:0] w_gray;
  logic       w_unused_pal;

  // Replicate the index MSB-first to fill 8 bits (data*17 for DW=4).
  always_comb begin
    w_gray = '0;
    for (int i = 0; i < 8; i++) begin
      w_gray[7-i] = data[DW - 1 - (i % DW)];
    end
  end

  assign w_rgb        = {3{w_gray}};
  assign w_unused_pal = ^{pal_we, pal_idx, pal_rgb};
`endif

  logic       r_hsync;
  logic       r_vsync;
  logic       r_blank_b;
  logic [7:0] r_red;
  logic [7:0] r_grn;
  logic [7:0] r_blu;

  // Stage 2: colour, syncs and blank all update together one tick after the address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hsync   <= ~SYNC_POL;
      r_vsync   <= ~SYNC_POL;
      r_blank_b <= 1'b0;
      r_red     <= '0;
      r_grn     <= '0;
      r_blu     <= '0;
    end else if (w_pix_tick) begin
      r_hsync                 <= r_hs1;
      r_vsync                 <= r_vs1;
      r_blank_b               <= r_rd_en;
      {r_red, r_grn, r_blu}   <= r_rd_en ? w_rgb : 24'h0;
    end
  end

  assign hsync   = r_hsync;
  assign vsync   = r_vsync;
  assign sync_b  = 1'b0;
  assign blank_b = r_blank_b;
  assign r       = r_red;
  assign g       = r_grn;
  assign b       = r_blu;
  assign address = r_address;
  assign rd_en   = r_rd_en;

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: directed bench for vga_scanout using a shrunken 16x8 mode.
// dut0: CLK_DIV=2, active-low syncs, no scaling. dut1: CLK_DIV=4, active-high
// syncs, SCALE_LOG2=1. Frame-buffer data is the inverted low address nibble.
module tb_vga_scanout;

  localparam int unsigned HA = 16, HF = 2, HS = 4, HB = 2;
  localparam int unsigned VA = 8, VF = 1, VS = 2, VB = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        vgaclk0, hsync0, vsync0, sync_b0, blank_b0, rd_en0, fs0;
  logic [7:0]  r0, g0, b0;
  logic [23:0] addr0;
  logic [3:0]  data0;
  logic        pal_we0;
  logic [3:0]  pal_idx0;
  logic [23:0] pal_rgb0;

  logic        vgaclk1, hsync1, vsync1, sync_b1, blank_b1, rd_en1, fs1;
  logic [7:0]  r1, g1, b1;
  logic [23:0] addr1;
  logic [3:0]  data1;
  logic        pal_we1 = 1'b0;
  logic [3:0]  pal_idx1 = 4'h0;
  logic [23:0] pal_rgb1 = 24'h0;

  assign data0 = ~addr0[3:0];
  assign data1 = ~addr1[3:0];

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .CLK_DIV(2), .SCALE_LOG2(0), .DW(4), .AW(24)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .vgaclk(vgaclk0), .hsync(hsync0), .vsync(vsync0),
    .sync_b(sync_b0), .blank_b(blank_b0), .r(r0), .g(g0), .b(b0), .address(addr0),
    .rd_en(rd_en0), .data(data0), .frame_start(fs0), .pal_we(pal_we0),
    .pal_idx(pal_idx0), .pal_rgb(pal_rgb0)
  );

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b1), .CLK_DIV(4), .SCALE_LOG2(1), .DW(4), .AW(24)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .vgaclk(vgaclk1), .hsync(hsync1), .vsync(vsync1),
    .sync_b(sync_b1), .blank_b(blank_b1), .r(r1), .g(g1), .b(b1), .address(addr1),
    .rd_en(rd_en1), .data(data1), .frame_start(fs1), .pal_we(pal_we1),
    .pal_idx(pal_idx1), .pal_rgb(pal_rgb1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // cyc: free-running clk count; rel: posedges since the last reset release.
  int cyc = 0;
  int rel = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rel <= rst_n ? rel + 1 : 0;
  end

  bit hs0_q = 1'b1, vs0_q = 1'b1, fs0_q = 1'b0, hs1_q = 1'b0;
  int hs0_fall = 0, hs0_fall_prev = 0, hs0_w = 0;
  int vs0_fall = 0, vs0_fall_prev = 0, vs0_w = 0;
  int fs0_t = 0, fs0_prev = 0;
  int hs1_rise = 0, hs1_rise_prev = 0, hs1_w = 0;
  logic [23:0] scale_q[$];

  // Edge time stamps and dut1 address capture (one entry per active pixel tick).
  always @(negedge clk) begin
    hs0_q <= hsync0;
    vs0_q <= vsync0;
    fs0_q <= fs0;
    hs1_q <= hsync1;
    if (hs0_q && !hsync0) begin hs0_fall_prev <= hs0_fall; hs0_fall <= cyc; end
    if (!hs0_q && hsync0) hs0_w <= cyc - hs0_fall;
    if (vs0_q && !vsync0) begin vs0_fall_prev <= vs0_fall; vs0_fall <= cyc; end
    if (!vs0_q && vsync0) vs0_w <= cyc - vs0_fall;
    if (!fs0_q && fs0) begin fs0_prev <= fs0_t; fs0_t <= cyc; end
    if (!hs1_q && hsync1) begin hs1_rise_prev <= hs1_rise; hs1_rise <= cyc; end
    if (hs1_q && !hsync1) hs1_w <= cyc - hs1_rise;
    if (rst_n && rel > 0 && rel % 4 == 0 && rd_en1 && scale_q.size() < 48)
      scale_q.push_back(addr1);
  end

  task automatic wait_rel(input int k);
    while (rel < k) @(negedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_hs0"}, hsync0, 1);
    check_eq({tag, "_vs0"}, vsync0, 1);
    check_eq({tag, "_blank0"}, blank_b0, 0);
    check_eq({tag, "_rgb0"}, {r0, g0, b0}, 0);
    check_eq({tag, "_addr0"}, addr0, 0);
    check_eq({tag, "_rden0"}, rd_en0, 0);
    check_eq({tag, "_fs0"}, fs0, 0);
    check_eq({tag, "_vgaclk0"}, vgaclk0, 0);
    check_eq({tag, "_hs1"}, hsync1, 0);
    check_eq({tag, "_vs1"}, vsync1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected summary");
    $fatal(1, "timeout");
  end

  initial begin
    logic [23:0] exp3;
    pal_we0  = 1'b0;
    pal_idx0 = 4'h0;
    pal_rgb0 = 24'h0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_state("rst");
    check_eq("sync_b0", sync_b0, 0);

    @(negedge clk);
    rst_n = 1'b1;

    wait_rel(1);
    check_eq("fs_first", fs0, 1);
    check_eq("vgaclk0_r1", vgaclk0, 1);
    check_eq("vgaclk1_r1", vgaclk1, 0);
    check_eq("rden_r1", rd_en0, 0);
    pal_we0  = 1'b1;
    pal_idx0 = 4'd3;
    pal_rgb0 = 24'h123456;

    wait_rel(2);
    pal_we0 = 1'b0;
    check_eq("fs_one_clk", fs0, 0);
    check_eq("addr_first", addr0, 0);
    check_eq("rden_first", rd_en0, 1);
    check_eq("blank_before", blank_b0, 0);
    check_eq("vgaclk0_r2", vgaclk0, 0);
    check_eq("vgaclk1_r2", vgaclk1, 1);

    wait_rel(4);
    check_eq("pix00_rgb", {r0, g0, b0}, 24'hFFFFFF);
    check_eq("pix00_blank", blank_b0, 1);
    check_eq("addr_next", addr0, 1);

    wait_rel(8);
    check_eq("d1_pix00_rgb", {r1, g1, b1}, 24'hFFFFFF);
    check_eq("d1_pix00_blank", blank_b1, 1);

    wait_rel(24);
    check_eq("pal_idx5", {r0, g0, b0}, 24'h555555);

    wait_rel(28);
`ifdef VGA_PALETTE_EN
    exp3 = 24'h123456;
`else
    exp3 = 24'h333333;
`endif
    check_eq("pal_idx3", {r0, g0, b0}, exp3);

    wait_rel(34);
    check_eq("last_active_blank", blank_b0, 1);
    wait_rel(36);
    check_eq("first_blank", blank_b0, 0);
    check_eq("first_blank_rgb", {r0, g0, b0}, 0);
    wait_rel(38);
    check_eq("hs0_pre", hsync0, 1);
    wait_rel(40);
    check_eq("hs0_start", hsync0, 0);
    check_eq("rden_blank", rd_en0, 0);
    check_eq("addr_hold", addr0, 15);

    wait_rel(68);
    check_eq("d1_last_rgb", {r1, g1, b1}, 24'h888888);
    check_eq("d1_last_blank", blank_b1, 1);
    wait_rel(72);
    check_eq("d1_blank", blank_b1, 0);
    check_eq("d1_blank_rgb", {r1, g1, b1}, 0);
    wait_rel(76);
    check_eq("d1_hs_pre", hsync1, 0);
    wait_rel(80);
    check_eq("d1_hs_start", hsync1, 1);

    wait_rel(576);
    check_eq("fs_wrap", fs0, 1);
    wait_rel(577);
    check_eq("fs_wrap_end", fs0, 0);

    wait_rel(1250);
    check_eq("hs0_period", hs0_fall - hs0_fall_prev, 48);
    check_eq("hs0_width", hs0_w, 8);
    check_eq("vs0_period", vs0_fall - vs0_fall_prev, 576);
    check_eq("vs0_width", vs0_w, 96);
    check_eq("fs0_period", fs0_t - fs0_prev, 576);
    check_eq("hs1_period", hs1_rise - hs1_rise_prev, 96);
    check_eq("hs1_width", hs1_w, 16);
    check_eq("scale_count", scale_q.size() >= 33, 1);
    if (scale_q.size() >= 33) begin
      for (int k = 0; k < 16; k++) begin
        check_eq($sformatf("scale_l0_%0d", k), scale_q[k], k >> 1);
        check_eq($sformatf("scale_l1_%0d", k), scale_q[16 + k], k >> 1);
      end
      check_eq("scale_l2_start", scale_q[32], 8);
    end

    wait_rel(1320);
    check_eq("pre_rst_blank", blank_b0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("midrst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_rel(1);
    check_eq("post_rst_fs", fs0, 1);
    wait_rel(2);
    check_eq("post_rst_fs_end", fs0, 0);
    check_eq("post_rst_addr", addr0, 0);
    check_eq("post_rst_rden", rd_en0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
